// File: rtl/ps2_keymap_timer.sv
// PS/2 Set-2 make code to ASCII (combinational) plus a start-edge delay timer: finish pulses DELAY cycles after rise, no backpressure.
// Build option PS2_UPPERCASE_EN: letters translate to 'A'..'Z' instead of 'a'..'z'; timer and other codes are unaffected.
module ps2_keymap_timer #(
    parameter int DELAY = 1000,
    parameter int CNT_W = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] scancode,
    output logic [7:0] ascii_out,
    input  logic       start,
    output logic       finish,
    output logic       busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] L_DELAY = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

`ifdef PS2_UPPERCASE_EN
    localparam logic [7:0] L_LETTER_BASE = 8'h41;
`else
    localparam logic [7:0] L_LETTER_BASE = 8'h61;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_start_q;
    logic             r_finish;
    logic             w_finish_nxt;
    logic             w_rise;

    assign w_rise = start & ~r_start_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_start_q <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_start_q <= start;
            r_finish  <= w_finish_nxt;
        end
    end

    // The terminal compare is checked before incrementing, so the counter never wraps.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = L_ONE;
                end
            end
            S_COUNT: begin
                if (r_cnt == L_DELAY) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Finish is registered: it is high exactly while the counter holds DELAY.
        w_finish_nxt = (w_state_nxt == S_COUNT) && (w_cnt_nxt == L_DELAY);
    end

    assign finish = r_finish;
    assign busy   = (r_state == S_COUNT);

    always_comb begin
        ascii_out = 8'h00;
        case (scancode)
            8'h1C: ascii_out = L_LETTER_BASE + 8'd0;
            8'h32: ascii_out = L_LETTER_BASE + 8'd1;
            8'h21: ascii_out = L_LETTER_BASE + 8'd2;
            8'h23: ascii_out = L_LETTER_BASE + 8'd3;
            8'h24: ascii_out = L_LETTER_BASE + 8'd4;
            8'h2B: ascii_out = L_LETTER_BASE + 8'd5;
            8'h34: ascii_out = L_LETTER_BASE + 8'd6;
            8'h33: ascii_out = L_LETTER_BASE + 8'd7;
            8'h43: ascii_out = L_LETTER_BASE + 8'd8;
            8'h3B: ascii_out = L_LETTER_BASE + 8'd9;
            8'h42: ascii_out = L_LETTER_BASE + 8'd10;
            8'h4B: ascii_out = L_LETTER_BASE + 8'd11;
            8'h3A: ascii_out = L_LETTER_BASE + 8'd12;
            8'h31: ascii_out = L_LETTER_BASE + 8'd13;
            8'h44: ascii_out = L_LETTER_BASE + 8'd14;
            8'h4D: ascii_out = L_LETTER_BASE + 8'd15;
            8'h15: ascii_out = L_LETTER_BASE + 8'd16;
            8'h2D: ascii_out = L_LETTER_BASE + 8'd17;
            8'h1B: ascii_out = L_LETTER_BASE + 8'd18;
            8'h2C: ascii_out = L_LETTER_BASE + 8'd19;
            8'h3C: ascii_out = L_LETTER_BASE + 8'd20;
            8'h2A: ascii_out = L_LETTER_BASE + 8'd21;
            8'h1D: ascii_out = L_LETTER_BASE + 8'd22;
            8'h22: ascii_out = L_LETTER_BASE + 8'd23;
            8'h35: ascii_out = L_LETTER_BASE + 8'd24;
            8'h1A: ascii_out = L_LETTER_BASE + 8'd25;
            8'h45: ascii_out = 8'h30;
            8'h16: ascii_out = 8'h31;
            8'h1E: ascii_out = 8'h32;
            8'h26: ascii_out = 8'h33;
            8'h25: ascii_out = 8'h34;
            8'h2E: ascii_out = 8'h35;
            8'h36: ascii_out = 8'h36;
            8'h3D: ascii_out = 8'h37;
            8'h3E: ascii_out = 8'h38;
            8'h46: ascii_out = 8'h39;
            8'h29: ascii_out = 8'h20;
            8'h5A: ascii_out = 8'h0D;
            8'h66: ascii_out = 8'h08;
            8'h76: ascii_out = 8'h1B;
            default: ascii_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ps2_keymap_timer.sv
// Randomised and directed checks of ps2_keymap_timer against an event-level model (DELAY=5).
module tb_ps2_keymap_timer;

    localparam int D = 5;

    logic       clock;
    logic       resetn;
    logic [7:0] scancode;
    logic [7:0] ascii_out;
    logic       start;
    logic       finish;
    logic       busy;

    ps2_keymap_timer #(.DELAY(D), .CNT_W(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .scancode  (scancode),
        .ascii_out (ascii_out),
        .start     (start),
        .finish    (finish),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Model: edge index of the accepted rise, if any.
    int   e = 0;
    int   k = 0;
    bit   have = 0;
    bit   prev = 0;
    logic s_busy, s_fin;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};

`ifdef PS2_UPPERCASE_EN
    localparam logic [7:0] LBASE = 8'h41;
`else
    localparam logic [7:0] LBASE = 8'h61;
`endif

    function automatic logic [7:0] ascii_model(input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++) if (letter_codes[i] == c) r = LBASE + 8'(i);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == c) r = 8'h30 + 8'(i);
        if (c == 8'h29) r = 8'h20;
        if (c == 8'h5A) r = 8'h0D;
        if (c == 8'h66) r = 8'h08;
        if (c == 8'h76) r = 8'h1B;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        else passed++;
    endtask

    // One clock cycle: drive at negedge, check ascii, model the edge, check timer outputs after it.
    task automatic step(input logic st, input logic rn);
        bit eb, ef;
        @(negedge clock);
        start    = st;
        resetn   = rn;
        scancode = 8'($urandom);
        #1;
        chk("ascii_rand", {24'd0, ascii_out}, {24'd0, ascii_model(scancode)});
        if (!rn) begin
            chk("busy_in_reset", {31'd0, busy}, 32'd0);
            chk("finish_in_reset", {31'd0, finish}, 32'd0);
        end
        @(posedge clock);
        e++;
        if (!rn) begin
            have = 0;
            prev = 0;
        end else begin
            if (st && !prev && (!have || e > k + D)) begin
                have = 1;
                k    = e;
            end
            prev = st;
        end
        #1;
        eb = have && (e >= k) && (e <= k + D - 1);
        ef = have && (e == k + D - 1);
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("finish", {31'd0, finish}, {31'd0, ef});
        s_busy = busy;
        s_fin  = finish;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    int nbusy, nfin, fidx, fidx2;
    logic st;
    logic [7:0] cc;

    initial begin
        start    = 1'b0;
        scancode = 8'h00;
        resetn   = 1'b0;
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_finish", {31'd0, finish}, 32'd0);
        do_reset();

        // Translator sweep plus literal pins.
        for (int i = 0; i < 256; i++) begin
            cc = 8'(i);
            scancode = cc;
            #1;
            chk("ascii_sweep", {24'd0, ascii_out}, {24'd0, ascii_model(cc)});
        end
        scancode = 8'h1C; #1; chk("ascii_1C", {24'd0, ascii_out}, {24'd0, LBASE});
        scancode = 8'h45; #1; chk("ascii_45", {24'd0, ascii_out}, 32'h30);
        scancode = 8'h29; #1; chk("ascii_29", {24'd0, ascii_out}, 32'h20);
        scancode = 8'h5A; #1; chk("ascii_5A", {24'd0, ascii_out}, 32'h0D);
        scancode = 8'hF0; #1; chk("ascii_F0", {24'd0, ascii_out}, 32'h00);
        scancode = 8'hE0; #1; chk("ascii_E0", {24'd0, ascii_out}, 32'h00);
        scancode = 8'h1A; #1; chk("ascii_1A", {24'd0, ascii_out}, {24'd0, LBASE + 8'd25});

        // Single pulse: busy for D cycles, finish on the last.
        nbusy = 0; nfin = 0; fidx = -1;
        for (int i = 0; i < 12; i++) begin
            step(i == 0, 1'b1);
            nbusy += int'(s_busy);
            if (s_fin) begin nfin++; fidx = i; end
        end
        chk("pulse_busy_len", nbusy, 5);
        chk("pulse_finish_cnt", nfin, 1);
        chk("pulse_finish_idx", fidx, 4);

        // Held high for 50 cycles: one finish only.
        nfin = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1);
            nfin += int'(s_fin);
        end
        step(1'b0, 1'b1);
        chk("held_finish_cnt", nfin, 1);

        // Retrigger two cycles into a count is ignored.
        nfin = 0; fidx = -1;
        for (int i = 0; i < 12; i++) begin
            step(i == 0 || i == 2, 1'b1);
            if (s_fin) begin nfin++; fidx = i; end
        end
        chk("retrig_finish_cnt", nfin, 1);
        chk("retrig_finish_idx", fidx, 4);

        // Reset mid-count aborts with no finish.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midreset_busy", {31'd0, s_busy}, 32'd0);
        nfin = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            nfin += int'(s_fin);
        end
        chk("midreset_finish_cnt", nfin, 0);

        // Back-to-back: rise the cycle after finish restarts; rise during finish is ignored.
        nfin = 0; fidx = -1; fidx2 = -1;
        for (int i = 0; i < 16; i++) begin
            step(i == 0 || i == 6, 1'b1);
            if (s_fin) begin
                nfin++;
                if (fidx < 0) fidx = i; else fidx2 = i;
            end
        end
        chk("b2b_finish_cnt", nfin, 2);
        chk("b2b_first_idx", fidx, 4);
        chk("b2b_second_idx", fidx2, 10);
        nfin = 0;
        for (int i = 0; i < 14; i++) begin
            step(i == 0 || i == 5 || i == 6, 1'b1);
            nfin += int'(s_fin);
        end
        chk("during_finish_ignored", nfin, 1);

        // Start high across reset release counts as a rise.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rise_at_reset_release", {31'd0, s_busy}, 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);

        // Randomised run with occasional resets.
        st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) st = ~st;
            step(st, $urandom_range(0, 99) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
